piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//   Parallel-in/serial-out transmitter that feeds the siso-style serial chain.
//   - Accepts N-bit words on a valid/ready handshake and shifts them out one bit
//     per clock, LSB first. This matches the bit order our serial shift
//     registers and deserializers expect.
//   - A one-entry holding buffer lets back-to-back words stream with no idle
//     cycle between them.
// PARAMETERS
//   N          4   word width in bits; legal values N >= 2
//   LSB_FIRST  1   1: bit 0 goes out first; 0: bit N-1 goes out first
// PORTS
//   clk           in   1  single clock; all logic on posedge
//   rst           in   1  synchronous, active-high reset
//   par_data      in   N  parallel word to send
//   par_valid     in   1  par_data is valid
//   par_ready     out  1  block can accept a word this cycle
//   serial_out    out  1  serial bit
//   serial_valid  out  1  serial_out carries a data bit this cycle
//   serial_last   out  1  serial_out carries the final bit of the word
//   busy          out  1  shifting, or a word is waiting in the hold buffer
// BEHAVIOUR
//   Reset
//     - rst is sampled at posedge clk and is synchronous, active-high.
//     - Reset values: serial_out=0, serial_valid=0, serial_last=0, busy=0,
//       par_ready=1, state=IDLE, bit_cnt=0, hold empty.
//     - rst asserted mid-word aborts the word and discards the hold contents.
//       Outputs take their reset values at that same edge, so no partial word
//       is reported after it.
//   Handshake
//     - A transfer occurs at a posedge when par_valid && par_ready.
//     - par_ready = !hold_full. It is derived from a register with no
//       combinational path from par_valid.
//   FSM states
//     - IDLE -> SHIFT: on a transfer. par_data loads straight into shift_reg,
//       bit_cnt=0, and the first bit is on serial_out in the next cycle
//       (latency: 1 clock from the accepting edge).
//     - SHIFT, not on the last bit: each edge advances one bit and increments
//       bit_cnt. A transfer in this state writes the hold buffer.
//     - SHIFT, last bit (bit_cnt==N-1) with hold full: load shift_reg from
//       hold, clear hold, stay in SHIFT. There is no gap.
//     - SHIFT, last bit, hold empty, transfer at this edge: bypass the hold
//       buffer and load par_data into shift_reg directly. There is no gap.
//     - SHIFT, last bit, hold empty, no transfer: go to IDLE and drop
//       serial_valid at this edge.
//   Outputs
//     - serial_out is registered and driven 0 whenever serial_valid=0.
//     - serial_last = serial_valid && bit_cnt==N-1.
//     - busy = (state==SHIFT) || hold_full.
//   Widths and timing
//     - bit_cnt is $clog2(N) bits wide and wraps 0..N-1, never beyond.
//     - Sustained throughput is one word per N clocks.
//     - par_ready stays high in SHIFT until the hold buffer fills.
// STRUCTURE
//   - Package shift_pkg holds the state encoding (typedef enum {IDLE, SHIFT})
//     and a helper function for the counter width, $clog2(N).
//   - One sub-module: piso_hold_buf, a one-entry register with a full flag and
//     write/read strobes.
//   - Top level contains the FSM, shift_reg, bit_cnt and the output registers.
// TESTING  (N=4, LSB_FIRST=1 unless stated)
//   - Single word: send 4'b1011 from IDLE.
//     -> serial_out 1,1,0,1 on the 4 cycles after acceptance.
//     -> serial_last high on the 4th bit only; then serial_valid=0, busy=0.
//   - Back-to-back: 4'hA then 4'h5 with par_valid held.
//     -> 8 contiguous valid bits 0,1,0,1,1,0,1,0.
//     -> par_ready drops after the 2nd word is accepted and recovers when that
//        word loads into shift_reg.
//   - Bypass: present 4'hC exactly on the cycle serial_last is high, hold empty.
//     -> Bits 0,0,1,1 follow with no idle cycle.
//   - Backpressure: hold full and par_valid=1 with 4'hF.
//     -> par_ready=0 and the word is not taken.
//     -> The word is accepted later, and each of the three words appears
//        exactly once on the line.
//   - Reset mid-word: assert rst after 2 bits of 4'h9.
//     -> All outputs reset at that edge and par_ready=1.
//     -> The next word 4'h3 goes out cleanly as 1,1,0,0.
//   - LSB_FIRST=0: send 4'b1000.
//     -> serial_out 1,0,0,0, with serial_last on the 4th bit.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the PISO serializer: FSM state encoding and bit-counter sizing.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding register that parks the next word while the current one shifts out.
module piso_hold_buf #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr,
  input  logic         i_rd,
  input  logic [N-1:0] i_data,
  output logic [N-1:0] o_data,
  output logic         o_full
);

  logic         r_full;
  logic [N-1:0] r_data;

  // Write only happens while empty and read only while full, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_wr) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_rd) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word input, one bit per clock out,
// with a one-word hold buffer so consecutive words stream without a gap.
//
//   state | meaning
//   IDLE  | nothing on the line, waiting for a word
//   SHIFT | serial_out carries bit r_bit_cnt of r_shift
module piso_serializer
  import shift_pkg::*;
#(
  parameter int N         = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] par_data,
  input  logic         par_valid,
  output logic         par_ready,
  output logic         serial_out,
  output logic         serial_valid,
  output logic         serial_last,
  output logic         busy
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_shift, w_shift_nxt;
  logic [CW-1:0] r_bit_cnt, w_cnt_nxt, w_idx;
  logic          r_sout, w_sout_nxt;
  logic          w_xfer, w_last;
  logic          w_hold_wr, w_hold_rd, w_hold_full;
  logic [N-1:0]  w_hold_data;

  assign w_xfer = par_valid && !w_hold_full;
  assign w_last = (r_bit_cnt == LAST);

  piso_hold_buf #(.N(N)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .i_wr   (w_hold_wr),
    .i_rd   (w_hold_rd),
    .i_data (par_data),
    .o_data (w_hold_data),
    .o_full (w_hold_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_bit_cnt;
    w_hold_wr   = 1'b0;
    w_hold_rd   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_state_nxt = SHIFT;
          w_shift_nxt = par_data;
          w_cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (!w_last) begin
          w_cnt_nxt = r_bit_cnt + CW'(1);
          w_hold_wr = w_xfer;
        end else if (w_hold_full) begin
          w_shift_nxt = w_hold_data;
          w_cnt_nxt   = '0;
          w_hold_rd   = 1'b1;
        end else if (w_xfer) begin
          // Hold is empty on the last bit: take the new word straight into the shifter.
          w_shift_nxt = par_data;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_idx      = LSB_FIRST ? w_cnt_nxt : (LAST - w_cnt_nxt);
    w_sout_nxt = (w_state_nxt == SHIFT) && w_shift_nxt[w_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_sout    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_sout    <= w_sout_nxt;
    end
  end

  assign serial_valid = (r_state == SHIFT);
  assign serial_out   = r_sout;
  assign serial_last  = serial_valid && w_last;
  assign busy         = serial_valid || w_hold_full;
  assign par_ready    = !w_hold_full;

endmodule
